// File: rtl/exec_muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM states and the iteration-count helper.
package exec_muldiv_seq_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_n(input int xlen, input int step);
        return xlen / step;
    endfunction

    function automatic logic is_div(input op_t op);
        return op[2];
    endfunction

    // rs0 is treated as signed for these ops.
    function automatic logic signed_rs0(input op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic signed_rs1(input op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM/REMU select the remainder; DIV/DIVU the quotient.
    function automatic logic wants_rem(input op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/exec_muldiv_seq_if.sv
// Request and response channels between an execution lane and the
// multiply/divide unit.
interface exec_muldiv_seq_if #(
    parameter int XLEN  = 32,
    parameter int RGBIT = 5
) ();

    // Both channels are valid/ready: a transfer happens on a rising clock edge
    // where valid and ready are both high; the source holds its payload stable
    // while valid is high and ready is low, and ready may depend on valid.
    logic             req_vld;
    logic             req_rdy;
    logic [2:0]       req_op;
    logic [RGBIT-1:0] req_rd;
    logic [XLEN-1:0]  req_rs0;
    logic [XLEN-1:0]  req_rs1;

    logic             rsp_vld;
    logic             rsp_rdy;
    logic [RGBIT-1:0] rsp_rd;
    logic [XLEN-1:0]  rsp_data;

    modport master (
        output req_vld, req_op, req_rd, req_rs0, req_rs1, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rd, rsp_data
    );

    modport slave (
        input  req_vld, req_op, req_rd, req_rs0, req_rs1, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rd, rsp_data
    );

endinterface

// File: rtl/exec_muldiv_seq_muldiv_step.sv
// One iteration of the shared datapath: STEP shift-add multiply bits or
// STEP restoring-division quotient bits, purely combinational.
module exec_muldiv_seq_muldiv_step #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic              div_mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   rem,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0]   rem_nxt,
    output logic [STEP-1:0]   q_bits
);

    logic [2*XLEN-1:0] a;
    logic [XLEN-1:0]   r;
    logic [STEP-1:0]   q;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     r_sh;
    logic [XLEN:0]     diff;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    // Divide: acc low half = {remaining dividend bits, quotient so far}, shifted
    // left; the vacated low STEP bits are left zero and filled from q_bits.
    always_comb begin
        a    = acc;
        r    = rem;
        q    = '0;
        sum  = '0;
        r_sh = '0;
        diff = '0;
        for (int i = 0; i < STEP; i++) begin
            if (div_mode) begin
                r_sh = {r, a[XLEN-1]};
                a    = a << 1;
                diff = r_sh - {1'b0, opnd};
                if (!diff[XLEN]) begin
                    r               = diff[XLEN-1:0];
                    q[STEP-1-i]     = 1'b1;
                end else begin
                    r = r_sh[XLEN-1:0];
                end
            end else begin
                sum = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
                a   = {sum, a[XLEN-1:1]};
            end
        end
        acc_nxt = a;
        rem_nxt = r;
        q_bits  = q;
    end

endmodule

// File: rtl/exec_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one operation in flight, STEP bits
// per cycle, divide-by-zero and signed-overflow resolved without iterating.
module exec_muldiv_seq
    import exec_muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RGBIT = 5,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    exec_muldiv_seq_if.slave bus,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int N  = calc_n(XLEN, STEP);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST    = CW'(N - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_nxt;

    logic             req_rdy;
    logic             accept;
    logic             last_iter;

    op_t              op_in;
    logic             sgn0, sgn1;
    logic [XLEN-1:0]  mag0, mag1;
    logic             div_zero, div_ovf, fast;
    logic [XLEN-1:0]  fast_data;

    op_t              op_q;
    logic [RGBIT-1:0] rd_q;
    logic             neg0_q, neg1_q;
    logic [XLEN-1:0]  opnd_q;
    logic [XLEN-1:0]  rem_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [XLEN-1:0]  data_q;

    logic [2*XLEN-1:0] acc_nxt, acc_upd, prod_s;
    logic [XLEN-1:0]   rem_nxt, quot_s, rem_s, result;
    logic [STEP-1:0]   q_bits;

    // ---------------- request decode ----------------
    always_comb begin
        op_in     = op_t'(bus.req_op);
        sgn0      = signed_rs0(op_in) & bus.req_rs0[XLEN-1];
        sgn1      = signed_rs1(op_in) & bus.req_rs1[XLEN-1];
        mag0      = sgn0 ? -bus.req_rs0 : bus.req_rs0;
        mag1      = sgn1 ? -bus.req_rs1 : bus.req_rs1;
        div_zero  = (bus.req_rs1 == '0);
        div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (bus.req_rs0 == INT_MIN) && (bus.req_rs1 == '1);
        fast      = is_div(op_in) & (div_zero | div_ovf);
        fast_data = '0;
        if (div_zero) begin
            fast_data = wants_rem(op_in) ? bus.req_rs0 : '1;
        end else if (div_ovf) begin
            fast_data = wants_rem(op_in) ? '0 : bus.req_rs0;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_rdy   = ~flush & ((state == IDLE) | ((state == DONE) & bus.rsp_rdy));
        accept    = bus.req_vld & req_rdy;
        last_iter = (state == CALC) && (cnt_q == LAST);
        case (state)
            IDLE: if (accept) state_nxt = fast ? DONE : CALC;
            CALC: if (last_iter) state_nxt = DONE;
            DONE: begin
                if (bus.rsp_rdy) begin
                    if (accept) state_nxt = fast ? DONE : CALC;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // ---------------- iteration datapath ----------------
    exec_muldiv_seq_muldiv_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) muldiv_step (
        .div_mode (is_div(op_q)),
        .acc      (acc_q),
        .rem      (rem_q),
        .opnd     (opnd_q),
        .acc_nxt  (acc_nxt),
        .rem_nxt  (rem_nxt),
        .q_bits   (q_bits)
    );

    // Sign correction and result select on the final iteration's values.
    always_comb begin
        acc_upd = acc_nxt;
        if (is_div(op_q)) acc_upd[STEP-1:0] = q_bits;
        prod_s = (neg0_q ^ neg1_q) ? -acc_upd : acc_upd;
        quot_s = (neg0_q ^ neg1_q) ? -acc_upd[XLEN-1:0] : acc_upd[XLEN-1:0];
        rem_s  = neg0_q ? -rem_nxt : rem_nxt;
        case (op_q)
            OP_MUL:                        result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               result = quot_s;
            default:                       result = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_MUL;
            rd_q   <= '0;
            neg0_q <= 1'b0;
            neg1_q <= 1'b0;
            opnd_q <= '0;
            rem_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= op_in;
            rd_q   <= bus.req_rd;
            neg0_q <= sgn0;
            neg1_q <= sgn1;
            rem_q  <= '0;
            cnt_q  <= '0;
            if (is_div(op_in)) begin
                opnd_q <= mag1;
                acc_q  <= {{XLEN{1'b0}}, mag0};
            end else begin
                opnd_q <= mag0;
                acc_q  <= {{XLEN{1'b0}}, mag1};
            end
            if (fast) data_q <= fast_data;
        end else if (state == CALC) begin
            acc_q <= acc_upd;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) data_q <= result;
        end
    end

    // ---------------- outputs ----------------
    assign bus.req_rdy  = req_rdy;
    assign bus.rsp_vld  = (state == DONE);
    assign bus.rsp_rd   = rd_q;
    assign bus.rsp_data = data_q;
    assign busy         = (state != IDLE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_exec_muldiv_seq.sv
// Bench for exec_muldiv_seq at STEP 1, 2 and 4 side by side, checked against
// a plain-arithmetic RV32M reference model.
module tb_exec_muldiv_seq;
    import exec_muldiv_seq_pkg::*;

    localparam int XLEN  = 32;
    localparam int RGBIT = 5;
    localparam int NDUT  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- shared stimulus, per-DUT observation ----------------
    logic             req_vld, rsp_rdy;
    logic [2:0]       req_op;
    logic [RGBIT-1:0] req_rd;
    logic [XLEN-1:0]  req_rs0, req_rs1;
    int               sel;

    logic [NDUT-1:0]  o_req_rdy, o_rsp_vld, o_busy;
    logic [RGBIT-1:0] o_rsp_rd   [NDUT];
    logic [XLEN-1:0]  o_rsp_data [NDUT];
    state_t           o_state    [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        exec_muldiv_seq_if #(.XLEN(XLEN), .RGBIT(RGBIT)) bus ();
        assign bus.req_vld    = req_vld & (sel == g);
        assign bus.req_op     = req_op;
        assign bus.req_rd     = req_rd;
        assign bus.req_rs0    = req_rs0;
        assign bus.req_rs1    = req_rs1;
        assign bus.rsp_rdy    = rsp_rdy;
        assign o_req_rdy[g]   = bus.req_rdy;
        assign o_rsp_vld[g]   = bus.rsp_vld;
        assign o_rsp_rd[g]    = bus.rsp_rd;
        assign o_rsp_data[g]  = bus.rsp_data;
        exec_muldiv_seq #(.XLEN(XLEN), .RGBIT(RGBIT), .STEP(ST)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .bus       (bus),
            .busy      (o_busy[g]),
            .dbg_state (o_state[g])
        );
    end

    // ---------------- scoreboard ----------------
    logic [RGBIT+XLEN-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        longint     sa, sb, ub;
        logic [63:0] p;
        logic [XLEN-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = sa * sb;                 r = p[63:32]; end
            3'd2: begin p = sa * ub;                 r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0)                                    r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0)                                    r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic is_fast(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        logic sgn_div;
        sgn_div = (op == 3'd4) || (op == 3'd6);
        return op[2] && ((b == 0) || (sgn_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic int step_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 2 : 4;
    endfunction

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks (entered just after a negedge) ----------------
    task automatic send(input int s, input logic [2:0] op, input logic [RGBIT-1:0] rd,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int w;
        sel = s; req_op = op; req_rd = rd; req_rs0 = a; req_rs1 = b; req_vld = 1'b1;
        w = 0;
        #1;
        while (!o_req_rdy[s] && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("req_rdy_accept", o_req_rdy[s], 1);
        exp_q.push_back({rd, ref_model(op, a, b)});
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic wait_rsp(input int s, input int exp_lat, input string tag);
        int lat;
        lat = 1;
        while (!o_rsp_vld[s] && lat < exp_lat + 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic take_rsp(input int s, input string tag, input int stall);
        logic [RGBIT+XLEN-1:0] e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        for (int i = 0; i <= stall; i++) begin
            check({tag, "_vld"},  o_rsp_vld[s],  1);
            check({tag, "_data"}, o_rsp_data[s], e[XLEN-1:0]);
            check({tag, "_rd"},   o_rsp_rd[s],   e[RGBIT+XLEN-1:XLEN]);
            if (i < stall) @(negedge clk);
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
    endtask

    task automatic run_op(input int s, input logic [2:0] op, input logic [RGBIT-1:0] rd,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input string tag, input int stall);
        logic fast;
        fast = is_fast(op, a, b);
        send(s, op, rd, a, b);
        if (fast) check({tag, "_fast_state"}, o_state[s], DONE);
        wait_rsp(s, fast ? 1 : XLEN / step_of(s) + 1, tag);
        take_rsp(s, tag, stall);
        check({tag, "_idle_vld"},  o_rsp_vld[s], 0);
        check({tag, "_idle_busy"}, o_busy[s],    0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int seen;
        rst = 1'b1; flush = 1'b0; req_vld = 1'b0; rsp_rdy = 1'b0; sel = 0;
        req_op = '0; req_rd = '0; req_rs0 = '0; req_rs1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset values
        check("rst_req_rdy",  o_req_rdy[0],  1);
        check("rst_rsp_vld",  o_rsp_vld[0],  0);
        check("rst_busy",     o_busy[0],     0);
        check("rst_rsp_rd",   o_rsp_rd[0],   0);
        check("rst_rsp_data", o_rsp_data[0], 0);

        // multiply / divide worked examples at STEP=1
        run_op(0, 3'd1, 5'd1, 32'hFFFF_FFFE, 32'h0000_0003, "mulh", 0);
        run_op(0, 3'd0, 5'd2, 32'hFFFF_FFFE, 32'h0000_0003, "mul", 0);
        run_op(0, 3'd4, 5'd3, 32'hFFFF_FFF9, 32'h0000_0002, "div", 0);
        run_op(0, 3'd6, 5'd4, 32'hFFFF_FFF9, 32'h0000_0002, "rem", 0);
        run_op(0, 3'd5, 5'd5, 32'd100, 32'd7, "divu", 0);
        run_op(0, 3'd7, 5'd0, 32'd100, 32'd7, "remu_rd0", 0);
        run_op(0, 3'd5, 5'd6, 32'd5, 32'd0, "divu_by0", 0);
        run_op(0, 3'd6, 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);

        // response back-pressure, then response + new accept in one cycle
        send(0, 3'd0, 5'd9, 32'h1234_5678, 32'h0000_0010);
        wait_rsp(0, XLEN + 1, "stall");
        sel = 0; req_op = 3'd5; req_rd = 5'd10; req_rs0 = 32'd1000; req_rs1 = 32'd9; req_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_data",    o_rsp_data[0], exp_q[0][XLEN-1:0]);
            check("stall_rd",      o_rsp_rd[0],   exp_q[0][RGBIT+XLEN-1:XLEN]);
            check("stall_req_rdy", o_req_rdy[0],  0);
            @(negedge clk);
        end
        check("b2b_old_data", o_rsp_data[0], exp_q[0][XLEN-1:0]);
        void'(exp_q.pop_front());
        rsp_rdy = 1'b1;
        #1;
        check("b2b_req_rdy", o_req_rdy[0], 1);
        exp_q.push_back({5'd10, ref_model(3'd5, 32'd1000, 32'd9)});
        @(negedge clk);
        req_vld = 1'b0; rsp_rdy = 1'b0;
        check("b2b_state", o_state[0], CALC);
        check("b2b_vld",   o_rsp_vld[0], 0);
        wait_rsp(0, XLEN + 1, "b2b");
        take_rsp(0, "b2b", 0);

        // flush in CALC cycle 10 with a competing request
        send(0, 3'd5, 5'd11, 32'hDEAD_BEEF, 32'd3);
        void'(exp_q.pop_back());
        repeat (9) @(negedge clk);
        flush = 1'b1; sel = 0; req_op = 3'd0; req_rd = 5'd12; req_rs0 = 32'd3; req_rs1 = 32'd4;
        req_vld = 1'b1;
        #1;
        check("flush_req_rdy", o_req_rdy[0], 0);
        @(negedge clk);
        flush = 1'b0; req_vld = 1'b0;
        check("flush_state", o_state[0], IDLE);
        check("flush_vld",   o_rsp_vld[0], 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_rsp_vld[0] || o_busy[0]) seen++;
        end
        check("flush_no_rsp", 64'(seen), 0);

        // reset pulse mid-CALC
        send(0, 3'd3, 5'd13, 32'hFFFF_0000, 32'h0001_FFFF);
        void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_req_rdy",  o_req_rdy[0],  1);
        check("mrst_rsp_vld",  o_rsp_vld[0],  0);
        check("mrst_busy",     o_busy[0],     0);
        check("mrst_rsp_rd",   o_rsp_rd[0],   0);
        check("mrst_rsp_data", o_rsp_data[0], 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_rsp_vld[0]) seen++;
        end
        check("mrst_no_rsp", 64'(seen), 0);

        // wider steps
        run_op(1, 3'd2, 5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_s2", 0);
        run_op(2, 3'd2, 5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_s4", 0);

        // randomized ops on every step width
        for (int s = 0; s < NDUT; s++) begin
            for (int k = 0; k < 30; k++) begin
                logic [2:0]      op;
                logic [XLEN-1:0] a, b;
                op = 3'($urandom_range(0, 7));
                a  = pick();
                b  = pick();
                run_op(s, op, 5'($urandom_range(0, 31)), a, b, "rand", $urandom_range(0, 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_muldiv_seq.md
# exec_muldiv_seq

Parametrised iterative execution unit for the RV32M multiply/divide operations. It sits beside the single-cycle ALU/branch unit in each execution lane. The ALU resolves add/logic/shift/branch in one cycle; this block accepts one M-extension operation at a time over a valid/ready handshake and processes `STEP` bits per cycle. It returns the tagged result to the register-writeback path over a second valid/ready handshake, and supports lane flush on branch mispredict.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; must be a multiple of `STEP`.
- `RGBIT`, 5: register index width.
- `STEP`, 1: bits retired per iteration; allowed values 1, 2, 4. Iteration count `N = XLEN/STEP`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  abort any operation in flight; drop any pending response.
- `req_vld`  in  1  request valid.
- `req_rdy`  out  1  unit can accept a request this cycle.
- `req_op`  in  3  funct3 encoding:
  - MUL=000, MULH=001, MULHSU=010, MULHU=011
  - DIV=100, DIVU=101, REM=110, REMU=111
- `req_rd`  in  RGBIT  destination register tag.
- `req_rs0`  in  XLEN  multiplicand / dividend.
- `req_rs1`  in  XLEN  multiplier / divisor.
- `rsp_vld`  out  1  result valid.
- `rsp_rdy`  in  1  writeback accepts the result.
- `rsp_rd`  out  RGBIT  tag of the result.
- `rsp_data`  out  XLEN  result.
- `busy`  out  1  state is not IDLE.

## Operation
- States and transitions:
  - IDLE → CALC on accept.
  - IDLE → DONE on accept of a fast-path op.
  - CALC → DONE after iteration `N-1`.
  - DONE → IDLE on `rsp_rdy` with no new accept.
  - DONE → CALC/DONE on `rsp_rdy` together with a same-cycle accept.
- Accept: `req_vld & req_rdy`. `req_rdy = ~flush & (state==IDLE | (state==DONE & rsp_rdy))`.
- On accept, latch op, rd, operand magnitudes, and the sign flags:
  - signed rs0 for MULH, MULHSU, DIV, REM;
  - signed rs1 for MULH, DIV, REM.
- Multiply: shift-add on magnitudes into a 2·XLEN accumulator, `STEP` multiplier bits per iteration. At the end, negate if the signs differ. MUL returns `[XLEN-1:0]`; the other multiplies return `[2XLEN-1:XLEN]`.
- Divide: restoring division on magnitudes, `STEP` quotient bits per iteration. Quotient sign is `s0^s1`; remainder sign is `s0`.
- Fast path (skips CALC, result valid in DONE):
  - divisor 0: quotient = all ones, remainder = rs0.
  - signed overflow (rs0 = `1<<(XLEN-1)`, rs1 = −1) on DIV/REM: quotient = rs0, remainder = 0.
- `rd==0`: the operation executes normally and the response is still produced; writeback discards it.
- `flush`: next state is IDLE from any state and `rsp_vld` drops the next cycle. No request is accepted in a flush cycle.
- `rsp_rd`/`rsp_data` hold stable while `rsp_vld & ~rsp_rdy`.

## Timing
- Reset: state IDLE.
- Output values after reset:
  - `req_rdy` = 1 from the first cycle after reset, unless `flush` is high.
  - `rsp_vld`, `busy`, `rsp_rd`, `rsp_data` = 0.
- Normal latency: accept at cycle 0 edge → CALC cycles 1..N → `rsp_vld` high from cycle N+1.
  - XLEN=32, STEP=1: 33 cycles.
  - XLEN=32, STEP=4: 9 cycles.
- Fast-path latency: `rsp_vld` high in cycle 1.
- Back-to-back: a response handshake and a new accept in the same cycle give zero bubble cycles in IDLE.
- Sign correction and result select are registered on the CALC→DONE edge; `rsp_data` is a flop output.
- Reset or flush during CALC: the partial result is discarded and no response is ever issued for that operation.

## Structure
- Shared package constants: op encodings (`OP_MUL`…`OP_REMU`), state enum (IDLE/CALC/DONE), `N` derivation function.
- Sub-module `muldiv_step`: purely combinational single iteration.
  - Inputs: mode, accumulator, remainder, operand, step bits.
  - Outputs: next accumulator, next remainder, quotient bits.
  - Instantiated once; the FSM, counter, sign logic and handshakes stay in the top.

## Test plan
- MULH 0xFFFF_FFFE × 0x0000_0003 (XLEN=32, STEP=1) → `rsp_data` 0xFFFF_FFFF, `rsp_vld` on cycle 33; MUL of the same operands → 0xFFFF_FFFA.
- DIV 0xFFFF_FFF9 (−7) / 2 → 0xFFFF_FFFD (−3); REM of the same operands → 0xFFFF_FFFF (−1); DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFF_FFFF in cycle 1; REM 0x8000_0000 / 0xFFFF_FFFF → 0, with `busy` never entering CALC.
- Hold `rsp_rdy` low 5 cycles → `rsp_data`/`rsp_rd` stable and `req_rdy` low; raise `rsp_rdy` with `req_vld` high → new op accepted in the same cycle.
- Assert `flush` in CALC cycle 10 with `req_vld` high → no accept, IDLE next cycle, no `rsp_vld` ever for the aborted op.
- `rst` pulse mid-CALC → all outputs 0 and `req_rdy` = 1 the next cycle; repeat the MULHSU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF check at STEP=2 and STEP=4 with latency N+1.
